approx_mul_error_monitor: RTL and testbench

- Downstream measurement stage for the unsigned 8x8 approximate multipliers.
- Consumes a stream of operand pairs (x, y) together with the approximate product z produced by the multiplier under evaluation.
- Recomputes the exact product and measures error distance ED = |z - x*y| for every sample.
- Over a window of WINDOW accepted samples, accumulates sum of ED, maximum ED and erroneous-sample count, which give MED / ER / WCE for the design-space sweep.

---
 rtl/approx_mul_error_monitor.sv | 150 +++++++++++++++
 tb/tb_approx_mul_error_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_error_monitor.sv
// Error-distance monitor for 8x8 approximate multipliers: recomputes the exact
// product and collects sum / max / count of |z - x*y| over a window of samples.
module approx_mul_error_monitor #(
    parameter int WINDOW = 65536,
    parameter int CNT_W  = 17,
    parameter int ACC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       x,
    input  logic [7:0]       y,
    input  logic [15:0]      z,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum_ed,
    output logic [15:0]      max_ed,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int EXT_W = ((ACC_W > 16) ? ACC_W : 16) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WINDOW);

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
    logic [15:0]      max_ed_q, max_ed_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

    logic             vld_p1_q, vld_p1_d;
    logic [7:0]       x_p1_q, y_p1_q;
    logic [15:0]      z_p1_q;
    logic             vld_p2_q, vld_p2_d;
    logic [15:0]      ed_p2_q, ed_p2_d;
    logic [15:0]      exact;
    logic             accept;

    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Widened add so a carry out of ACC_W bits pins the sum at all-ones.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [15:0] ed);
        logic [EXT_W-1:0] s;
        s = EXT_W'(acc) + EXT_W'(ed);
        if (s > EXT_W'(ACC_MAX)) return ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    always_comb begin
        accept   = in_valid & in_ready_q;
        exact    = 16'(x_p1_q) * 16'(y_p1_q);
        ed_p2_d  = abs_diff(z_p1_q, exact);
        vld_p1_d = accept;
        vld_p2_d = vld_p1_q;

        state_d      = state_q;
        sum_ed_d     = sum_ed_q;
        max_ed_d     = max_ed_q;
        err_cnt_d    = err_cnt_q;
        sample_cnt_d = sample_cnt_q;

        // Stage 3: fold the finished ED into the run statistics
        if (vld_p2_q) begin
            sum_ed_d = sat_add(sum_ed_q, ed_p2_q);
            if (ed_p2_q > max_ed_q) max_ed_d = ed_p2_q;
            if (ed_p2_q != 16'd0) err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    sum_ed_d     = '0;
                    max_ed_d     = '0;
                    err_cnt_d    = '0;
                    sample_cnt_d = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    if (sample_cnt_d == WIN_C) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!vld_p1_q && !vld_p2_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == RUN);
        busy_d     = (state_d == RUN) || (state_d == DRAIN);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sum_ed_q     <= '0;
            max_ed_q     <= '0;
            err_cnt_q    <= '0;
            sample_cnt_q <= '0;
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sum_ed_q     <= sum_ed_d;
            max_ed_q     <= max_ed_d;
            err_cnt_q    <= err_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
        end
    end

    // Stages 1 and 2 data path: qualified by the valids, so no reset needed
    always_ff @(posedge clk) begin
        x_p1_q  <= x;
        y_p1_q  <= y;
        z_p1_q  <= z;
        ed_p2_q <= ed_p2_d;
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sum_ed     = sum_ed_q;
    assign max_ed     = max_ed_q;
    assign err_cnt    = err_cnt_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_approx_mul_error_monitor.sv
// Directed bench for approx_mul_error_monitor: three instances with different
// WINDOW / ACC_W share one input bus and are started one at a time.
module tb_approx_mul_error_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  x, y;
    logic [15:0] z;
    logic        start16, start2, start4;

    logic        ready16, busy16, done16;
    logic [31:0] sum16;
    logic [15:0] max16;
    logic [16:0] err16, cnt16;

    logic        ready2, busy2, done2;
    logic [31:0] sum2;
    logic [15:0] max2;
    logic [16:0] err2, cnt2;

    logic        ready4, busy4, done4;
    logic [16:0] sum4;
    logic [15:0] max4;
    logic [16:0] err4, cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    approx_mul_error_monitor #(.WINDOW(16), .CNT_W(17), .ACC_W(32)) u16 (
        .clk(clk), .rst(rst), .start(start16), .in_valid(in_valid), .in_ready(ready16),
        .x(x), .y(y), .z(z), .busy(busy16), .done(done16), .sum_ed(sum16),
        .max_ed(max16), .err_cnt(err16), .sample_cnt(cnt16));

    approx_mul_error_monitor #(.WINDOW(2), .CNT_W(17), .ACC_W(32)) u2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(ready2),
        .x(x), .y(y), .z(z), .busy(busy2), .done(done2), .sum_ed(sum2),
        .max_ed(max2), .err_cnt(err2), .sample_cnt(cnt2));

    approx_mul_error_monitor #(.WINDOW(4), .CNT_W(17), .ACC_W(17)) u4 (
        .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(ready4),
        .x(x), .y(y), .z(z), .busy(busy4), .done(done4), .sum_ed(sum4),
        .max_ed(max4), .err_cnt(err4), .sample_cnt(cnt4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [31:0] s, input logic [15:0] m,
                         input logic [16:0] e, input logic [16:0] c);
        chk({tag, "_sum"}, sum16, s);
        chk({tag, "_max"}, max16, m);
        chk({tag, "_err"}, err16, e);
        chk({tag, "_cnt"}, cnt16, c);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; z = '0;
        start16 = 1'b0; start2 = 1'b0; start4 = 1'b0;
        tick(); tick();
        chk("rst_ready", ready16, 1'b0);
        chk("rst_busy", busy16, 1'b0);
        chk("rst_done", done16, 1'b0);
        chk16("rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Exact products, back-to-back
        start16 = 1'b1; tick(); start16 = 1'b0;
        chk("t1_busy", busy16, 1'b1);
        chk("t1_ready", ready16, 1'b1);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            x = 8'(i * 13 + 1);
            y = 8'(255 - i * 7);
            z = 16'(x) * 16'(y);
            tick();
        end
        in_valid = 1'b0;
        chk("t1_ready_drop", ready16, 1'b0);
        chk("t1_busy_drain", busy16, 1'b1);
        chk("t1_cnt_last", cnt16, 17'd16);
        tick(); chk("t1_done_k1", done16, 1'b0);
        tick(); chk("t1_done_k2", done16, 1'b0);
        tick(); chk("t1_done_k3", done16, 1'b1);
        chk16("t1", 0, 0, 0, 16);
        tick(); chk("t1_done_k4", done16, 1'b0);
        chk("t1_busy_end", busy16, 1'b0);

        // ED=5 on every sample, alternating bubbles, start pulse in RUN
        start16 = 1'b1; tick(); start16 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_valid = (i % 2) == 1;
            start16 = (i == 10);
            x = 8'(i + 2);
            y = 8'(i + 7);
            z = (i % 2 == 1) ? 16'(x) * 16'(y) + 16'd5 : 16'hBEEF;
            tick();
        end
        in_valid = 1'b0;
        chk("t2_cnt_last", cnt16, 17'd16);
        chk("t2_ready_drop", ready16, 1'b0);
        start16 = 1'b1; tick(); start16 = 1'b0;
        chk("t2_drain_start", busy16, 1'b1);
        tick(); chk("t2_done_k2", done16, 1'b0);
        tick(); chk("t2_done_k3", done16, 1'b1);
        chk16("t2", 80, 5, 16, 16);
        start16 = 1'b1; tick(); start16 = 1'b0;
        chk("t2_after_done_busy", busy16, 1'b0);
        chk("t2_after_done_done", done16, 1'b0);
        chk16("t2_held", 80, 5, 16, 16);
        tick();
        chk16("t2_idle_held", 80, 5, 16, 16);
        start16 = 1'b1; tick(); start16 = 1'b0;
        chk16("t5_clear", 0, 0, 0, 0);
        chk("t5_busy", busy16, 1'b1);

        // Reset after 7 accepts of an erroneous run
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            x = 8'(i + 1); y = 8'd9;
            z = 16'(x) * 16'(y) + 16'd1;
            tick();
        end
        in_valid = 1'b0;
        chk16("t6_pre", 5, 1, 5, 7);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_busy", busy16, 1'b0);
        chk("t6_ready", ready16, 1'b0);
        chk16("t6_rst", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_done", done16, 1'b0);
            tick();
        end

        // Clean run after reset: ED = i for sample i
        start16 = 1'b1; tick(); start16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            x = 8'd10; y = 8'd10;
            z = 16'd100 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("t6b_done", done16, 1'b1);
        chk16("t6b", 120, 15, 15, 16);

        // Underestimates, WINDOW=2
        start2 = 1'b1; tick(); start2 = 1'b0;
        in_valid = 1'b1; x = 8'd255; y = 8'd255; z = 16'd0; tick();
        x = 8'd3; y = 8'd3; z = 16'd10; tick();
        in_valid = 1'b0;
        chk("t3_ready_drop", ready2, 1'b0);
        chk("t3_u16_idle_cnt", cnt16, 17'd16);
        tick(); tick(); tick();
        chk("t3_done", done2, 1'b1);
        chk("t3_sum", sum2, 32'd65026);
        chk("t3_max", max2, 16'd65025);
        chk("t3_err", err2, 17'd2);
        chk("t3_cnt", cnt2, 17'd2);

        // Saturation with ACC_W=17, WINDOW=4
        start4 = 1'b1; tick(); start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x = 8'd0; y = 8'(i * 50 + 1); z = 16'hFFFF;
            tick();
        end
        in_valid = 1'b0;
        chk("t4_sum_mid", sum4, 17'd131070);
        tick(); tick(); tick();
        chk("t4_done", done4, 1'b1);
        chk("t4_sum_sat", sum4, 17'd131071);
        chk("t4_max", max4, 16'd65535);
        chk("t4_err", err4, 17'd4);
        tick();
        chk("t4_done_end", done4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
